sgmii_tx_sequencer: RTL and testbench

- Synthesizable transmit-side code-group sequencer for the SGMII link.
- Sits directly upstream of the 8b/10b encoder (encode) and emits exactly one byte plus K flag per sgmii_clk_in cycle.
- Arbitrates between three sources:
  - idle ordered sets (/I1/, /I2/)
  - auto-negotiation config ordered sets (/C1/, /C2/)
  - framed Ethernet packets: /S/, preamble, SFD, payload, /T/, /R/
- Enforces even-alignment of ordered sets and a minimum inter-packet gap.

---
 rtl/sgmii_tx_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_sgmii_tx_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sgmii_tx_sequencer.sv
// SGMII transmit code-group sequencer: arbitrates idle, auto-negotiation config
// and framed packets into one byte + K flag per clock for the 8b/10b encoder.
module sgmii_tx_sequencer #(
   parameter int MIN_IPG_SETS = 6,
   parameter int IPG_CNT_W    = 8
) (
   input  logic        sgmii_clk_in,
   input  logic        reset,
   input  logic        an_enable,
   input  logic [15:0] an_config,
   input  logic        disp_in,
   input  logic [7:0]  pkt_data,
   input  logic        pkt_valid,
   input  logic        pkt_last,
   output logic        pkt_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_is_k,
   output logic        tx_even,
   output logic        pkt_err
);

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K30_7 = 8'hFE;
   localparam logic [7:0] D5_6  = 8'hC5;
   localparam logic [7:0] D16_2 = 8'h50;
   localparam logic [7:0] D21_5 = 8'hB5;
   localparam logic [7:0] D2_2  = 8'h42;
   localparam logic [7:0] PREAM = 8'h55;
   localparam logic [7:0] SFD   = 8'hD5;

   localparam logic [IPG_CNT_W-1:0] IPG_MIN = IPG_CNT_W'(MIN_IPG_SETS);
   localparam logic [IPG_CNT_W-1:0] IPG_MAX = {IPG_CNT_W{1'b1}};

   // Each state names the code-group currently on tx_byte.
   typedef enum logic [3:0] {
      ST_IDLE_K, ST_IDLE_D, ST_CFG, ST_SOP, ST_PRE, ST_SFD,
      ST_DATA, ST_LAST, ST_VOID, ST_EOP_T, ST_EOP_R, ST_EOP_R2
   } state_e;

   state_e               state_q, state_d, arb_state;
   logic [2:0]           cfg_idx_q, cfg_idx_d;
   logic [2:0]           pre_cnt_q, pre_cnt_d;
   logic [15:0]          cfg_word_q, cfg_word_d;
   logic [IPG_CNT_W-1:0] ipg_cnt_q, ipg_cnt_d;
   logic                 drain_q, drain_d;
   logic [7:0]           tx_byte_q, tx_byte_d;
   logic                 tx_is_k_q, tx_is_k_d;
   logic                 tx_even_q;
   logic                 pkt_ready_q, pkt_ready_d;
   logic                 pkt_err_q, pkt_err_d;

   // Choice made at an even boundary: config beats packets beats idle.
   always_comb begin
      arb_state = ST_IDLE_K;
      if (an_enable) begin
         arb_state = ST_CFG;
      end else if (pkt_valid && !drain_q && (ipg_cnt_q >= IPG_MIN)) begin
         arb_state = ST_SOP;
      end else begin
         arb_state = ST_IDLE_K;
      end
   end

   // Next-state sequencing and underrun detection.
   always_comb begin
      state_d   = state_q;
      pkt_err_d = 1'b0;
      case (state_q)
         ST_IDLE_K: state_d = ST_IDLE_D;
         ST_IDLE_D: state_d = arb_state;
         ST_CFG: begin
            if (cfg_idx_q == 3'd7) state_d = arb_state;
            else                   state_d = ST_CFG;
         end
         ST_SOP: state_d = ST_PRE;
         ST_PRE: begin
            if (pre_cnt_q == 3'd5) state_d = ST_SFD;
            else                   state_d = ST_PRE;
         end
         ST_SFD, ST_DATA: begin
            if (!pkt_valid) begin
               state_d   = ST_VOID;
               pkt_err_d = 1'b1;
            end else if (pkt_last) begin
               state_d = ST_LAST;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_LAST, ST_VOID: state_d = ST_EOP_T;
         ST_EOP_T:  state_d = ST_EOP_R;
         ST_EOP_R: begin
            if (tx_even_q) state_d = ST_EOP_R2;
            else           state_d = arb_state;
         end
         ST_EOP_R2: state_d = arb_state;
         default:   state_d = ST_IDLE_K;
      endcase
   end

   // Counters, drain flag and the config word sampled at each /C/ set start.
   always_comb begin
      if (state_q == ST_CFG) cfg_idx_d = cfg_idx_q + 3'd1;
      else                   cfg_idx_d = 3'd0;
      if (state_q == ST_PRE) pre_cnt_d = pre_cnt_q + 3'd1;
      else                   pre_cnt_d = 3'd0;
      if ((state_d == ST_CFG) && (cfg_idx_d[1:0] == 2'd0)) cfg_word_d = an_config;
      else                                                 cfg_word_d = cfg_word_q;
      if (state_d == ST_SOP) begin
         ipg_cnt_d = '0;
      end else if ((state_q == ST_IDLE_K) && (ipg_cnt_q != IPG_MAX)) begin
         ipg_cnt_d = ipg_cnt_q + 1'b1;
      end else begin
         ipg_cnt_d = ipg_cnt_q;
      end
      if (pkt_err_d) begin
         drain_d = 1'b1;
      end else if (drain_q && pkt_valid && pkt_ready_q && pkt_last) begin
         drain_d = 1'b0;
      end else begin
         drain_d = drain_q;
      end
      pkt_ready_d = (state_d == ST_SFD) || (state_d == ST_DATA) || drain_d;
   end

   // Code-group decode for the next output position.
   always_comb begin
      tx_byte_d = K28_5;
      tx_is_k_d = 1'b1;
      case (state_d)
         ST_IDLE_K: begin tx_byte_d = K28_5; tx_is_k_d = 1'b1; end
         ST_IDLE_D: begin tx_byte_d = disp_in ? D5_6 : D16_2; tx_is_k_d = 1'b0; end
         ST_CFG: begin
            case (cfg_idx_d)
               3'd0, 3'd4: begin tx_byte_d = K28_5;             tx_is_k_d = 1'b1; end
               3'd1:       begin tx_byte_d = D21_5;             tx_is_k_d = 1'b0; end
               3'd5:       begin tx_byte_d = D2_2;              tx_is_k_d = 1'b0; end
               3'd2, 3'd6: begin tx_byte_d = cfg_word_d[7:0];   tx_is_k_d = 1'b0; end
               3'd3, 3'd7: begin tx_byte_d = cfg_word_d[15:8];  tx_is_k_d = 1'b0; end
               default:    begin tx_byte_d = K28_5;             tx_is_k_d = 1'b1; end
            endcase
         end
         ST_SOP:             begin tx_byte_d = K27_7;    tx_is_k_d = 1'b1; end
         ST_PRE:             begin tx_byte_d = PREAM;    tx_is_k_d = 1'b0; end
         ST_SFD:             begin tx_byte_d = SFD;      tx_is_k_d = 1'b0; end
         ST_DATA, ST_LAST:   begin tx_byte_d = pkt_data; tx_is_k_d = 1'b0; end
         ST_VOID:            begin tx_byte_d = K30_7;    tx_is_k_d = 1'b1; end
         ST_EOP_T:           begin tx_byte_d = K29_7;    tx_is_k_d = 1'b1; end
         ST_EOP_R, ST_EOP_R2: begin tx_byte_d = K23_7;   tx_is_k_d = 1'b1; end
         default:            begin tx_byte_d = K28_5;    tx_is_k_d = 1'b1; end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge sgmii_clk_in or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE_K;
         cfg_idx_q   <= 3'd0;
         pre_cnt_q   <= 3'd0;
         cfg_word_q  <= 16'h0000;
         ipg_cnt_q   <= '0;
         drain_q     <= 1'b0;
         tx_byte_q   <= K28_5;
         tx_is_k_q   <= 1'b1;
         tx_even_q   <= 1'b1;
         pkt_ready_q <= 1'b0;
         pkt_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_idx_q   <= cfg_idx_d;
         pre_cnt_q   <= pre_cnt_d;
         cfg_word_q  <= cfg_word_d;
         ipg_cnt_q   <= ipg_cnt_d;
         drain_q     <= drain_d;
         tx_byte_q   <= tx_byte_d;
         tx_is_k_q   <= tx_is_k_d;
         tx_even_q   <= ~tx_even_q;
         pkt_ready_q <= pkt_ready_d;
         pkt_err_q   <= pkt_err_d;
      end
   end

   assign tx_byte   = tx_byte_q;
   assign tx_is_k   = tx_is_k_q;
   assign tx_even   = tx_even_q;
   assign pkt_ready = pkt_ready_q;
   assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_sgmii_tx_sequencer.sv
// Directed, table-driven bench for sgmii_tx_sequencer: each record holds the
// inputs for one clock and the hand-computed outputs after that edge.
module tb_sgmii_tx_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        an_enable;
   logic [15:0] an_config;
   logic        disp_in;
   logic [7:0]  pkt_data;
   logic        pkt_valid;
   logic        pkt_last;
   logic        pkt_ready;
   logic [7:0]  tx_byte;
   logic        tx_is_k;
   logic        tx_even;
   logic        pkt_err;

   always #5 clk = ~clk;

   sgmii_tx_sequencer #(.MIN_IPG_SETS(6), .IPG_CNT_W(8)) dut (
      .sgmii_clk_in(clk), .reset(reset), .an_enable(an_enable), .an_config(an_config),
      .disp_in(disp_in), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last),
      .pkt_ready(pkt_ready), .tx_byte(tx_byte), .tx_is_k(tx_is_k), .tx_even(tx_even),
      .pkt_err(pkt_err)
   );

   typedef struct {
      logic        an;
      logic [15:0] cfg;
      logic        disp;
      logic [7:0]  data;
      logic        valid;
      logic        last;
      logic [7:0]  e_byte;
      logic        e_k;
      logic        e_rdy;
      logic        e_err;
   } vec_t;

   vec_t        tbl[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          split;
   logic        exp_even;
   logic        h_an = 1'b0, h_disp = 1'b0, h_valid = 1'b0, h_last = 1'b0;
   logic [15:0] h_cfg = 16'h0000;
   logic [7:0]  h_data = 8'h00;

   task automatic add(input logic [7:0] eb, input logic ek, input logic er, input logic ee);
      vec_t v;
      v.an = h_an; v.cfg = h_cfg; v.disp = h_disp; v.data = h_data;
      v.valid = h_valid; v.last = h_last;
      v.e_byte = eb; v.e_k = ek; v.e_rdy = er; v.e_err = ee;
      tbl.push_back(v);
   endtask

   task automatic add_idle(input int sets, input logic er);
      for (int s = 0; s < sets; s++) begin
         add(8'hBC, 1'b1, er, 1'b0);
         add(8'h50, 1'b0, er, 1'b0);
      end
   endtask

   task automatic add_pre();
      for (int p = 0; p < 6; p++) add(8'h55, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input logic [7:0] eb, input logic ek,
                        input logic ev, input logic er, input logic ee);
      n_vec++;
      if ({tx_byte, tx_is_k, tx_even, pkt_ready, pkt_err} !== {eb, ek, ev, er, ee}) begin
         n_bad++;
         $display("FAIL %s: got byte=%h k=%b even=%b ready=%b err=%b, want byte=%h k=%b even=%b ready=%b err=%b",
                  name, tx_byte, tx_is_k, tx_even, pkt_ready, pkt_err, eb, ek, ev, er, ee);
      end
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         an_enable = tbl[i].an; an_config = tbl[i].cfg; disp_in = tbl[i].disp;
         pkt_data = tbl[i].data; pkt_valid = tbl[i].valid; pkt_last = tbl[i].last;
         @(posedge clk);
         #1;
         exp_even = ~exp_even;
         check($sformatf("vec%0d", i), tbl[i].e_byte, tbl[i].e_k, exp_even,
               tbl[i].e_rdy, tbl[i].e_err);
      end
   endtask

   initial begin
      // Idle with /I2/, then one /I1/ after disp_in rises during a BC cycle.
      add(8'h50, 1'b0, 1'b0, 1'b0); add(8'hBC, 1'b1, 1'b0, 1'b0);
      add(8'h50, 1'b0, 1'b0, 1'b0); add(8'hBC, 1'b1, 1'b0, 1'b0);
      h_disp = 1'b1; add(8'hC5, 1'b0, 1'b0, 1'b0);
      h_disp = 1'b0; add(8'hBC, 1'b1, 1'b0, 1'b0); add(8'h50, 1'b0, 1'b0, 1'b0);
      // Auto-negotiation: word change mid-set, then enable dropped mid-pair.
      h_an = 1'b1; h_cfg = 16'h4001;
      add(8'hBC, 1'b1, 1'b0, 1'b0); add(8'hB5, 1'b0, 1'b0, 1'b0);
      add(8'h01, 1'b0, 1'b0, 1'b0); add(8'h40, 1'b0, 1'b0, 1'b0);
      add(8'hBC, 1'b1, 1'b0, 1'b0); add(8'h42, 1'b0, 1'b0, 1'b0);
      add(8'h01, 1'b0, 1'b0, 1'b0); add(8'h40, 1'b0, 1'b0, 1'b0);
      add(8'hBC, 1'b1, 1'b0, 1'b0); add(8'hB5, 1'b0, 1'b0, 1'b0);
      h_cfg = 16'h0020;
      add(8'h01, 1'b0, 1'b0, 1'b0); add(8'h40, 1'b0, 1'b0, 1'b0);
      add(8'hBC, 1'b1, 1'b0, 1'b0); add(8'h42, 1'b0, 1'b0, 1'b0);
      add(8'h20, 1'b0, 1'b0, 1'b0); add(8'h00, 1'b0, 1'b0, 1'b0);
      add(8'hBC, 1'b1, 1'b0, 1'b0);
      h_an = 1'b0;
      add(8'hB5, 1'b0, 1'b0, 1'b0); add(8'h20, 1'b0, 1'b0, 1'b0);
      add(8'h00, 1'b0, 1'b0, 1'b0); add(8'hBC, 1'b1, 1'b0, 1'b0);
      add(8'h42, 1'b0, 1'b0, 1'b0); add(8'h20, 1'b0, 1'b0, 1'b0);
      add(8'h00, 1'b0, 1'b0, 1'b0); add(8'hBC, 1'b1, 1'b0, 1'b0);
      // Packet 11,22,33: denied at 5 idle sets (config does not count), sent at 6.
      h_valid = 1'b1; h_data = 8'h11;
      add(8'h50, 1'b0, 1'b0, 1'b0); add(8'hBC, 1'b1, 1'b0, 1'b0);
      add(8'h50, 1'b0, 1'b0, 1'b0); add(8'hFB, 1'b1, 1'b0, 1'b0);
      add_pre(); add(8'hD5, 1'b0, 1'b1, 1'b0);
      add(8'h11, 1'b0, 1'b1, 1'b0);
      h_data = 8'h22; add(8'h22, 1'b0, 1'b1, 1'b0);
      h_data = 8'h33; h_last = 1'b1; add(8'h33, 1'b0, 1'b0, 1'b0);
      // Back-to-back 4-byte packet: 12 idle bytes, single /R/.
      h_data = 8'hAA; h_last = 1'b0;
      add(8'hFD, 1'b1, 1'b0, 1'b0); add(8'hF7, 1'b1, 1'b0, 1'b0); add(8'hF7, 1'b1, 1'b0, 1'b0);
      add_idle(6, 1'b0); add(8'hFB, 1'b1, 1'b0, 1'b0);
      add_pre(); add(8'hD5, 1'b0, 1'b1, 1'b0);
      add(8'hAA, 1'b0, 1'b1, 1'b0);
      h_data = 8'hBB; add(8'hBB, 1'b0, 1'b1, 1'b0);
      h_data = 8'hCC; add(8'hCC, 1'b0, 1'b1, 1'b0);
      h_data = 8'hDD; h_last = 1'b1; add(8'hDD, 1'b0, 1'b0, 1'b0);
      // Underrun after two bytes, then a long tail that must be drained.
      h_data = 8'hE1; h_last = 1'b0;
      add(8'hFD, 1'b1, 1'b0, 1'b0); add(8'hF7, 1'b1, 1'b0, 1'b0);
      add_idle(6, 1'b0); add(8'hFB, 1'b1, 1'b0, 1'b0);
      add_pre(); add(8'hD5, 1'b0, 1'b1, 1'b0);
      add(8'hE1, 1'b0, 1'b1, 1'b0);
      h_data = 8'hE2; add(8'hE2, 1'b0, 1'b1, 1'b0);
      h_valid = 1'b0; add(8'hFE, 1'b1, 1'b1, 1'b1);
      h_valid = 1'b1; h_data = 8'hE3;
      add(8'hFD, 1'b1, 1'b1, 1'b0); add(8'hF7, 1'b1, 1'b1, 1'b0); add(8'hF7, 1'b1, 1'b1, 1'b0);
      add_idle(6, 1'b1); add(8'hBC, 1'b1, 1'b1, 1'b0);
      h_data = 8'hE4; h_last = 1'b1; add(8'h50, 1'b0, 1'b0, 1'b0);
      h_data = 8'h5A; add(8'hFB, 1'b1, 1'b0, 1'b0);
      add_pre(); add(8'hD5, 1'b0, 1'b1, 1'b0); add(8'h5A, 1'b0, 1'b0, 1'b0);
      h_valid = 1'b0; h_last = 1'b0;
      add(8'hFD, 1'b1, 1'b0, 1'b0); add(8'hF7, 1'b1, 1'b0, 1'b0); add(8'hF7, 1'b1, 1'b0, 1'b0);
      add(8'hBC, 1'b1, 1'b0, 1'b0); add(8'h50, 1'b0, 1'b0, 1'b0);
      // Packet that will be cut by reset two bytes into the preamble.
      h_valid = 1'b1; h_data = 8'h77; h_last = 1'b1;
      add_idle(5, 1'b0); add(8'hFB, 1'b1, 1'b0, 1'b0);
      add(8'h55, 1'b0, 1'b0, 1'b0); add(8'h55, 1'b0, 1'b0, 1'b0);
      split = tbl.size();
      // After reset the packet waits a full 6 idle sets again.
      add(8'h50, 1'b0, 1'b0, 1'b0); add_idle(5, 1'b0); add(8'hFB, 1'b1, 1'b0, 1'b0);
      add_pre(); add(8'hD5, 1'b0, 1'b1, 1'b0); add(8'h77, 1'b0, 1'b0, 1'b0);
      h_valid = 1'b0; h_last = 1'b0;
      add(8'hFD, 1'b1, 1'b0, 1'b0); add(8'hF7, 1'b1, 1'b0, 1'b0); add(8'hF7, 1'b1, 1'b0, 1'b0);
      add(8'hBC, 1'b1, 1'b0, 1'b0); add(8'h50, 1'b0, 1'b0, 1'b0);

      reset = 1'b0; an_enable = 1'b0; an_config = 16'h0000; disp_in = 1'b0;
      pkt_data = 8'h00; pkt_valid = 1'b0; pkt_last = 1'b0;
      #12;
      check("reset_values", 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_even = 1'b1;
      #1 reset = 1'b1;
      run_range(0, split);

      // Asynchronous reset in the preamble: outputs change with no clock edge.
      reset = 1'b0;
      #2;
      check("async_reset", 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_hold", 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      exp_even = 1'b1;
      run_range(split, tbl.size());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
